// File: rtl/pipeline_hold_ctrl.sv
// rtl/pipeline_hold_ctrl.sv - PC/IF-ID/ID-EX hold, flush and redirect control for a 5-stage RV32I pipeline
// Mealy control outputs; counters and pending redirect are registered.
module pipeline_hold_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_LIMIT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            STALL_REQ,
  input  logic            REDIRECT_VALID,
  input  logic [XLEN-1:0] REDIRECT_PC,
  input  logic            HALT,
  output logic            PC_EN,
  output logic            PC_SEL,
  output logic [XLEN-1:0] PC_TARGET,
  output logic            FD_EN,
  output logic            FD_FLUSH,
  output logic            DE_EN,
  output logic            DE_BUBBLE,
  output logic            STALL_TIMEOUT,
  output logic [CNT_W-1:0] STALL_CYCLES
);

  localparam int RUN_W = $clog2(STALL_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(STALL_LIMIT);
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALTED} state_t;

  localparam state_t REDIR_NEXT = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;

  state_t           state, state_nxt;
  logic [3:0]       flush_cnt, flush_cnt_nxt;
  logic [RUN_W-1:0] stall_run, stall_run_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic [XLEN-1:0]  pend_pc, pend_pc_nxt;
  logic             stall_cycle;

  logic            pc_en_c, pc_sel_c, fd_en_c, fd_flush_c, de_en_c, de_bubble_c;
  logic [XLEN-1:0] target_c;

  always_comb begin
    state_nxt      = state;
    flush_cnt_nxt  = flush_cnt;
    pend_valid_nxt = pend_valid;
    pend_pc_nxt    = pend_pc;
    stall_cycle    = 1'b0;
    pc_en_c        = 1'b1;
    pc_sel_c       = 1'b0;
    target_c       = '0;
    fd_en_c        = 1'b1;
    fd_flush_c     = 1'b0;
    de_en_c        = 1'b1;
    de_bubble_c    = 1'b0;

    if (HALT) begin
      pc_en_c   = 1'b0;
      fd_en_c   = 1'b0;
      de_en_c   = 1'b0;
      state_nxt = S_HALTED;
      // Latest redirect during halt wins; it is replayed on release.
      if (REDIRECT_VALID) begin
        pend_valid_nxt = 1'b1;
        pend_pc_nxt    = REDIRECT_PC;
      end
    end else if (REDIRECT_VALID || (state == S_HALTED && pend_valid)) begin
      pc_sel_c       = 1'b1;
      target_c       = REDIRECT_VALID ? REDIRECT_PC : pend_pc;
      fd_flush_c     = 1'b1;
      de_bubble_c    = 1'b1;
      pend_valid_nxt = 1'b0;
      flush_cnt_nxt  = FLUSH_LOAD;
      state_nxt      = REDIR_NEXT;
    end else begin
      case (state)
        S_FLUSH: begin
          fd_flush_c  = 1'b1;
          de_bubble_c = 1'b1;
          if (flush_cnt <= 4'd1) begin
            flush_cnt_nxt = 4'd0;
            state_nxt     = S_RUN;
          end else begin
            flush_cnt_nxt = flush_cnt - 4'd1;
          end
        end
        S_HALTED: state_nxt = S_RUN;
        default: begin
          if (STALL_REQ) begin
            pc_en_c     = 1'b0;
            fd_en_c     = 1'b0;
            de_bubble_c = 1'b1;
            stall_cycle = 1'b1;
          end
        end
      endcase
    end

    if (!stall_cycle)
      stall_run_nxt = '0;
    else if (stall_run == RUN_MAX)
      stall_run_nxt = RUN_MAX;
    else
      stall_run_nxt = stall_run + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= S_RUN;
      flush_cnt     <= '0;
      stall_run     <= '0;
      pend_valid    <= 1'b0;
      pend_pc       <= '0;
      STALL_CYCLES  <= '0;
      STALL_TIMEOUT <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_cnt  <= flush_cnt_nxt;
      stall_run  <= stall_run_nxt;
      pend_valid <= pend_valid_nxt;
      pend_pc    <= pend_pc_nxt;
      if (stall_cycle && (STALL_CYCLES != {CNT_W{1'b1}}))
        STALL_CYCLES <= STALL_CYCLES + 1'b1;
      if (stall_run_nxt == RUN_MAX)
        STALL_TIMEOUT <= 1'b1;
    end
  end

  // Outputs fall to their safe values as soon as reset asserts.
  assign PC_EN     = RST_N & pc_en_c;
  assign PC_SEL    = RST_N & pc_sel_c;
  assign PC_TARGET = RST_N ? target_c : '0;
  assign FD_EN     = RST_N & fd_en_c;
  assign FD_FLUSH  = ~RST_N | fd_flush_c;
  assign DE_EN     = RST_N & de_en_c;
  assign DE_BUBBLE = ~RST_N | de_bubble_c;

endmodule

// File: doc/pipeline_hold_ctrl.md
Name: pipeline_hold_ctrl

Overview:
Consumer end of the hazard/stall interface. Takes the stall request from the decode-stage hazard detector, plus the branch/jump redirect and halt from the execute stage. Drives PC write, the IF/ID and ID/EX register enables, flush/bubble controls and PC source select for the 5-stage RV32I pipeline. It also holds redirects that arrive during halt, times out stuck stalls, and counts stall cycles for performance monitoring.

Parameters:
XLEN, 32, PC width
FLUSH_CYCLES, 2, cycles IF/ID is squashed after a redirect (1..15), covers instruction-memory latency
STALL_LIMIT, 255, consecutive stall cycles that raise STALL_TIMEOUT
CNT_W, 16, width of the stall performance counter

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
STALL_REQ  input  1  hazard detected in decode (combinational from hazard detector)
REDIRECT_VALID  input  1  taken branch/jump resolved in EX this cycle
REDIRECT_PC  input  XLEN  redirect target
HALT  input  1  level halt request (ecall/debug)
PC_EN  output  1  PC register write enable
PC_SEL  output  1  0 = PC+4, 1 = PC_TARGET
PC_TARGET  output  XLEN  redirect target presented to PC mux
FD_EN  output  1  IF/ID register enable
FD_FLUSH  output  1  IF/ID loads NOP
DE_EN  output  1  ID/EX register enable
DE_BUBBLE  output  1  ID/EX loads NOP
STALL_TIMEOUT  output  1  sticky: stall exceeded STALL_LIMIT
STALL_CYCLES  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (RST_N low, async): state RUN; flush counter, stall-run counter, STALL_CYCLES, STALL_TIMEOUT and pending-redirect register all 0.
- While RST_N is low: PC_EN=0, FD_EN=0, DE_EN=0, FD_FLUSH=1, DE_BUBBLE=1, PC_SEL=0, PC_TARGET=0.
- Control outputs are combinational from state and inputs (Mealy). A stall or redirect takes effect in the same cycle it is asserted. All registers update on the rising edge of CLK.
- States: RUN, FLUSH, HALTED.
- Priority each cycle: HALT > REDIRECT_VALID > STALL_REQ > normal.
- HALT (any state): PC_EN=0, FD_EN=0, DE_EN=0, DE_BUBBLE=0, FD_FLUSH=0. Next state is HALTED.
  - A REDIRECT_VALID seen while HALT is high is captured into the pending register. A later redirect overwrites it.
- HALTED with HALT low: apply the pending redirect if one is held. Otherwise resume RUN with all enables 1.
- Redirect (live or pending): PC_EN=1, PC_SEL=1, PC_TARGET=target, FD_EN=1, FD_FLUSH=1, DE_EN=1, DE_BUBBLE=1.
  - Pending register clears. Flush counter loads FLUSH_CYCLES-1.
  - Next state is FLUSH if FLUSH_CYCLES>1, otherwise RUN.
  - STALL_REQ is ignored in that cycle, because the stalled instruction is squashed.
- FLUSH: FD_FLUSH=1, DE_BUBBLE=1, PC_EN=1, PC_SEL=0, all enables 1. STALL_REQ is ignored. Counter decrements; RUN is entered on the cycle after the counter reaches 0.
  - A new redirect in FLUSH is applied immediately and reloads the counter.
- Stall (RUN, STALL_REQ=1, no redirect/halt): PC_EN=0, FD_EN=0, DE_EN=1, DE_BUBBLE=1, FD_FLUSH=0.
  - STALL_CYCLES increments and saturates at all-ones.
  - Stall-run counter increments and saturates at STALL_LIMIT. When it equals STALL_LIMIT, STALL_TIMEOUT is set and stays set until reset.
  - The stall-run counter clears on any non-stall cycle.
- Normal RUN: PC_EN=1, PC_SEL=0, FD_EN=1, DE_EN=1, FD_FLUSH=0, DE_BUBBLE=0.
- PC_TARGET equals REDIRECT_PC, or the pending PC when replaying. It is 0 when PC_SEL=0.

Test Plan:
- Reset release then idle for 3 cycles -> PC_EN=FD_EN=DE_EN=1, FD_FLUSH=DE_BUBBLE=0, STALL_CYCLES=0.
- STALL_REQ high for 3 cycles -> PC_EN=FD_EN=0 and DE_BUBBLE=1 for exactly those 3 cycles, then STALL_CYCLES=3 and normal flow resumes.
- REDIRECT_VALID with REDIRECT_PC=0x0000_0100 and STALL_REQ together, FLUSH_CYCLES=2 -> cycle 0: PC_SEL=1, PC_TARGET=0x100, FD_FLUSH=DE_BUBBLE=1. Cycle 1: FLUSH with PC_SEL=0 and FD_FLUSH=1. Cycle 2: RUN. STALL_CYCLES does not increment.
- HALT high, REDIRECT_VALID to 0x200 then to 0x300 during the halt, then HALT low -> all enables 0 while halted. On the release cycle PC_SEL=1 and PC_TARGET=0x300, then the flush sequence runs.
- STALL_LIMIT=4 with STALL_REQ held for 6 cycles -> STALL_TIMEOUT rises after the 4th stall cycle and stays 1 after STALL_REQ drops. An async RST_N pulse clears it mid-cycle.
- RST_N asserted mid-FLUSH -> outputs take the reset values immediately. After release the block is in RUN with no residual flush.
